extint_scheduler: RTL and testbench
===================================

Name: extint_scheduler

Overview:
- Prioritising scheduler between the external-interrupt edge sources and the core's single external-interrupt input.
- Latches rising edges into pending bits and masks them per source. Selects the highest-priority candidate above a threshold and drives the core trigger.
- Sequences a claim/complete handshake over the standard peripheral bus, so only one source is in service at a time.

Parameters:
- SRC_NUM, 8, number of interrupt sources (1..16); source IDs are 1..SRC_NUM, ID 0 means "none".
- PRIO_W, 2, priority field width per source; priority 0 means never taken.
- ADDR_W, 5, bus byte-address width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- ext_int_src  in  SRC_NUM  level inputs from IPs; a rising edge is the event
- ext_int_trigger  out  1  interrupt request to core
- addr  in  ADDR_W  bus byte address
- w_rb  in  1  1=write, 0=read
- acc  in  BUS_ACC_WIDTH  access size; only BUS_ACC_4B is legal
- wdata  in  BUS_WIDTH  write data
- rdata  out  BUS_WIDTH  read data, registered
- req  in  1  bus request
- resp  out  1  registered response, one cycle after an accepted req
- fault  out  1  combinational, req & invalid

Behaviour:
- Reset: everything is cleared asynchronously on rstn low; the rising edge of rstn is synchronised internally.
  - Reset values: ext_int_trigger=0, resp=0, rdata=0, pending=0, enable=0, prio=0, threshold=0, in_service=0, state=IDLE, edge-detect history=0.
  - A reset mid-service drops in_service with no completion needed.
- Edge detect: a registered previous copy of ext_int_src; pulse = src & ~prev; the pulse sets pending[i] on the next edge, regardless of enable.
- Register map (byte offsets; all accesses 32-bit; unused bits read 0):
  - 0x00 ENABLE: RW, [SRC_NUM-1:0].
  - 0x04 PENDING: RO.
  - 0x08 PRIO: RW, packed, source i at [i*PRIO_W +: PRIO_W].
  - 0x0C THRESHOLD: RW, [PRIO_W-1:0].
  - 0x10 CLAIM: read = claim, write = complete.
- fault conditions: acc != 4B, addr not in the map, addr[1:0] != 0, or a write to PENDING. A faulting access has no side effects and resp stays 0.
- Candidate: the pending & enabled source with prio > threshold and the highest prio; ties go to the lowest index. best_id = index+1, or 0 if none. The arbiter is purely combinational over registered state.
- FSM:
  - IDLE: ext_int_trigger=0; go to ARMED when best_id != 0.
  - ARMED: ext_int_trigger=1.
    - CLAIM read: rdata<=best_id, pending[best_id-1] cleared, in_service<=best_id, go to SERVICE.
    - If the candidate vanishes (ENABLE, PRIO or THRESHOLD changed), return to IDLE the next cycle.
  - SERVICE: ext_int_trigger=0, no preemption.
    - CLAIM reads return 0 with no side effects.
    - A CLAIM write with wdata[4:0]==in_service goes to IDLE; a mismatched write is ignored (resp still 1, no fault).
  - In IDLE or ARMED, a CLAIM write is ignored. A CLAIM read in IDLE returns 0.
- Latency:
  - Source edge to ext_int_trigger: 3 cycles (prev register, pending set, FSM to ARMED).
  - Complete to the next trigger: 2 cycles when another candidate is pending.
- Simultaneous events:
  - An edge arriving on the source being claimed in the same cycle: set wins, pending stays 1.
  - An edge on the in-service source during SERVICE re-pends it.
  - A bus write to ENABLE/PRIO/THRESHOLD takes effect on the next cycle's arbitration.

Decomposition:
- Shared package/header constants:
  - EXT_INT_SRC_NUM and BUS_ACC_4B from the existing femto.vh.
  - New header defines: EXTSCH_ENABLE=5'h00, EXTSCH_PENDING=5'h04, EXTSCH_PRIO=5'h08, EXTSCH_THRESH=5'h0C, EXTSCH_CLAIM=5'h10.
  - FSM state encodings IDLE=2'd0, ARMED=2'd1, SERVICE=2'd2.
- Sub-module extint_prio_arb: combinational max-priority/lowest-index select with inputs cand[SRC_NUM] and packed prio, output best_id. Reusable and separately testable.

Test Plan:
- Reset, then register readback:
  - All registers read 0.
  - Write ENABLE=0xFF, PRIO=0xE4E4, THRESHOLD=1; read back 0xFF, 0xE4E4, 0x1.
  - A PENDING write faults with resp=0.
  - acc=2B faults.
- Single source, ENABLE=0x01, PRIO=0x0003, THRESHOLD=0:
  - Rising edge on src[0] gives ext_int_trigger=1 three cycles later.
  - CLAIM read returns 1; trigger drops, PENDING reads 0.
  - Write 1 to CLAIM; the FSM returns to IDLE.
- Priority and tie:
  - Sources 2 and 5 at prio 3 and source 1 at prio 2, all pending; claims return 3, then 6, then 2, each after a completion.
- Threshold masking:
  - THRESHOLD=2 with source 0 at prio 2 pending: no trigger.
  - Set THRESHOLD=1: trigger in 2 cycles, claim returns 1.
- Service blocking and re-pend:
  - During SERVICE of ID 1, a second edge on src[0] sets PENDING=0x1 with trigger held 0.
  - A CLAIM read returns 0; writing the wrong ID 2 keeps SERVICE.
  - Writing 1 completes, and the trigger re-asserts 2 cycles later.
- Async reset mid-service:
  - Pull rstn low asynchronously mid-cycle in SERVICE; trigger, resp and pending clear immediately.
  - After release, an edge is needed to re-trigger.

Source files
------------

// File: rtl/extint_scheduler_pkg.sv
// Shared constants, register offsets and FSM encoding for the external-interrupt scheduler.
package extint_scheduler_pkg;

  localparam int EXT_INT_SRC_NUM = 8;
  localparam int BUS_WIDTH       = 32;
  localparam int BUS_ACC_WIDTH   = 2;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  // Source IDs run 1..16 with 0 meaning "none", so five bits are needed
  localparam int ID_W = 5;

  localparam logic [4:0] EXTSCH_ENABLE  = 5'h00;
  localparam logic [4:0] EXTSCH_PENDING = 5'h04;
  localparam logic [4:0] EXTSCH_PRIO    = 5'h08;
  localparam logic [4:0] EXTSCH_THRESH  = 5'h0C;
  localparam logic [4:0] EXTSCH_CLAIM   = 5'h10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVICE = 2'd2
  } extsch_state_t;

endpackage

// File: rtl/extint_scheduler_if.sv
// Peripheral bus seen by the scheduler: request/response with combinational fault.
interface extint_scheduler_if import extint_scheduler_pkg::*; #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0]        addr;
  logic                     w_rb;
  logic [BUS_ACC_WIDTH-1:0] acc;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH-1:0]     rdata;
  logic                     req;
  logic                     resp;
  logic                     fault;

  modport master (
    output addr, w_rb, acc, wdata, req,
    input  rdata, resp, fault
  );

  modport slave (
    input  addr, w_rb, acc, wdata, req,
    output rdata, resp, fault
  );
endinterface

// File: rtl/extint_prio_arb.sv
// Combinational arbiter: highest priority among candidates, lowest index on ties.
module extint_prio_arb import extint_scheduler_pkg::*; #(
  parameter int SRC_NUM = EXT_INT_SRC_NUM,
  parameter int PRIO_W  = 2
) (
  input  logic [SRC_NUM-1:0]        cand,
  input  logic [SRC_NUM*PRIO_W-1:0] prio,
  output logic [ID_W-1:0]           best_id
);

  logic [PRIO_W-1:0] best_prio;

  // Strict '>' keeps the first (lowest-index) winner and never selects prio 0
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (cand[i] && (prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = prio[i*PRIO_W +: PRIO_W];
        best_id   = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/extint_scheduler.sv
// External-interrupt scheduler: edge latching, masking, priority select and claim/complete FSM.
module extint_scheduler import extint_scheduler_pkg::*; #(
  parameter int SRC_NUM = EXT_INT_SRC_NUM,
  parameter int PRIO_W  = 2,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [SRC_NUM-1:0] ext_int_src,
  output logic               ext_int_trigger,
  extint_scheduler_if.slave  bus
);

  localparam int PW = SRC_NUM * PRIO_W;

  logic [1:0]         rst_sync;
  logic               rst_int_n;
  logic [SRC_NUM-1:0] src_q;
  logic [SRC_NUM-1:0] src_prev;
  logic [SRC_NUM-1:0] edge_pulse;
  logic [SRC_NUM-1:0] pending;
  logic [SRC_NUM-1:0] enable;
  logic [SRC_NUM-1:0] cand;
  logic [SRC_NUM-1:0] clr_mask;
  logic [PW-1:0]      prio;
  logic [PRIO_W-1:0]  threshold;
  logic [ID_W-1:0]    in_service;
  logic [ID_W-1:0]    best_id;
  extsch_state_t      state;

  logic sel_en, sel_pend, sel_prio, sel_thr, sel_claim;
  logic invalid, wr_ok, rd_ok, claim_take, complete;
  logic [BUS_WIDTH-1:0] rd_val;

  // Assertion is immediate through rst_sync; release is seen two edges later
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign sel_en    = (bus.addr == ADDR_W'(EXTSCH_ENABLE));
  assign sel_pend  = (bus.addr == ADDR_W'(EXTSCH_PENDING));
  assign sel_prio  = (bus.addr == ADDR_W'(EXTSCH_PRIO));
  assign sel_thr   = (bus.addr == ADDR_W'(EXTSCH_THRESH));
  assign sel_claim = (bus.addr == ADDR_W'(EXTSCH_CLAIM));

  assign invalid = (bus.acc != BUS_ACC_4B)
                 | ~(sel_en | sel_pend | sel_prio | sel_thr | sel_claim)
                 | (bus.addr[1:0] != 2'b00)
                 | (bus.w_rb & sel_pend);

  assign bus.fault = bus.req & invalid;
  assign wr_ok     = bus.req & ~invalid & bus.w_rb;
  assign rd_ok     = bus.req & ~invalid & ~bus.w_rb;

  assign claim_take = rd_ok & sel_claim & (state == ARMED) & (best_id != '0);
  assign complete   = wr_ok & sel_claim & (state == SERVICE)
                    & (bus.wdata[ID_W-1:0] == in_service);

  assign edge_pulse = src_q & ~src_prev;

  always_comb begin
    cand     = '0;
    clr_mask = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      cand[i]     = pending[i] & enable[i] & (prio[i*PRIO_W +: PRIO_W] > threshold);
      clr_mask[i] = claim_take & (best_id == ID_W'(i + 1));
    end
  end

  extint_prio_arb #(
    .SRC_NUM (SRC_NUM),
    .PRIO_W  (PRIO_W)
  ) u_arb (
    .cand    (cand),
    .prio    (prio),
    .best_id (best_id)
  );

  always_comb begin
    rd_val = '0;
    if (sel_en)    rd_val = BUS_WIDTH'(enable);
    if (sel_pend)  rd_val = BUS_WIDTH'(pending);
    if (sel_prio)  rd_val = BUS_WIDTH'(prio);
    if (sel_thr)   rd_val = BUS_WIDTH'(threshold);
    if (sel_claim) rd_val = claim_take ? BUS_WIDTH'(best_id) : '0;
  end

  // Stage boundary: sampled sources, edge history and pending set-wins-over-claim
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      src_q    <= '0;
      src_prev <= '0;
      pending  <= '0;
    end else begin
      src_q    <= ext_int_src;
      src_prev <= src_q;
      pending  <= (pending & ~clr_mask) | edge_pulse;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      enable    <= '0;
      prio      <= '0;
      threshold <= '0;
      bus.resp  <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.resp  <= bus.req & ~invalid;
      bus.rdata <= rd_ok ? rd_val : '0;
      if (wr_ok && sel_en)   enable    <= bus.wdata[SRC_NUM-1:0];
      if (wr_ok && sel_prio) prio      <= bus.wdata[PW-1:0];
      if (wr_ok && sel_thr)  threshold <= bus.wdata[PRIO_W-1:0];
    end
  end

  // Stage boundary: claim/complete FSM with registered trigger
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state           <= IDLE;
      in_service      <= '0;
      ext_int_trigger <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ext_int_trigger <= 1'b0;
          if (best_id != '0) begin
            state           <= ARMED;
            ext_int_trigger <= 1'b1;
          end
        end
        ARMED: begin
          if (claim_take) begin
            state           <= SERVICE;
            in_service      <= best_id;
            ext_int_trigger <= 1'b0;
          end else if (best_id == '0) begin
            state           <= IDLE;
            ext_int_trigger <= 1'b0;
          end
        end
        SERVICE: begin
          ext_int_trigger <= 1'b0;
          if (complete) begin
            state      <= IDLE;
            in_service <= '0;
          end
        end
        default: begin
          state           <= IDLE;
          in_service      <= '0;
          ext_int_trigger <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extint_scheduler.sv
// Directed and randomized bench for extint_scheduler with a behavioural scheduler model.
module tb_extint_scheduler;
  import extint_scheduler_pkg::*;

  logic       clk;
  logic       rstn;
  logic [7:0] src;
  logic       trig;
  int checks   = 0;
  int failures = 0;

  extint_scheduler_if #(.ADDR_W(5)) bus_if ();

  extint_scheduler #(.SRC_NUM(8), .PRIO_W(2), .ADDR_W(5)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .ext_int_src     (src),
    .ext_int_trigger (trig),
    .bus             (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model: what software would expect to see
  logic [7:0] m_en;
  logic [7:0] m_pend;
  logic [1:0] m_prio [8];
  logic [1:0] m_thr;

  function automatic int m_best();
    for (int p = 3; p > int'(m_thr); p--)
      for (int i = 0; i < 8; i++)
        if (m_pend[i] && m_en[i] && int'(m_prio[i]) == p) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_prio_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 8; i++) w[i*2 +: 2] = m_prio[i];
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic xfer(input logic w, input logic [4:0] a, input logic [1:0] ac,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic rs, output logic flt);
    bus_if.req   = 1'b1;
    bus_if.w_rb  = w;
    bus_if.addr  = a;
    bus_if.acc   = ac;
    bus_if.wdata = wd;
    #1 flt = bus_if.fault;
    @(posedge clk);
    @(negedge clk);
    rd = bus_if.rdata;
    rs = bus_if.resp;
    bus_if.req  = 1'b0;
    bus_if.w_rb = 1'b0;
  endtask

  task automatic wr32(input string tag, input logic [4:0] a, input logic [31:0] d);
    logic [31:0] rd; logic rs, flt;
    xfer(1'b1, a, BUS_ACC_4B, d, rd, rs, flt);
    check({tag, "_resp"}, {31'd0, rs}, 32'd1);
  endtask

  task automatic rd32(input string tag, input logic [4:0] a, output logic [31:0] d);
    logic rs, flt;
    xfer(1'b0, a, BUS_ACC_4B, 32'd0, d, rs, flt);
    check({tag, "_resp"}, {31'd0, rs}, 32'd1);
  endtask

  task automatic cfg(input logic [7:0] en, input logic [31:0] pw, input logic [1:0] th);
    m_en = en; m_thr = th;
    for (int i = 0; i < 8; i++) m_prio[i] = pw[i*2 +: 2];
    wr32("cfg_en", EXTSCH_ENABLE, {24'd0, en});
    wr32("cfg_prio", EXTSCH_PRIO, m_prio_word());
    wr32("cfg_thr", EXTSCH_THRESH, {30'd0, th});
  endtask

  // One-cycle high pulse on the masked sources; returns one edge later
  task automatic raise(input logic [7:0] mask);
    src = mask;
    @(negedge clk);
    src = 8'd0;
    m_pend = m_pend | mask;
  endtask

  task automatic claim_expect(input string tag, input int exp);
    logic [31:0] d;
    rd32(tag, EXTSCH_CLAIM, d);
    check(tag, d, 32'(exp));
    if (exp != 0) m_pend[exp-1] = 1'b0;
  endtask

  task automatic model_reset();
    m_en = '0; m_pend = '0; m_thr = '0;
    for (int i = 0; i < 8; i++) m_prio[i] = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic rs, flt;
    int exp, n;

    src = 8'd0;
    bus_if.req = 1'b0; bus_if.w_rb = 1'b0; bus_if.addr = '0;
    bus_if.acc = BUS_ACC_4B; bus_if.wdata = '0;
    model_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    tick(3);
    check("rst_trigger", {31'd0, trig}, 32'd0);
    check("rst_resp", {31'd0, bus_if.resp}, 32'd0);
    check("rst_rdata", bus_if.rdata, 32'd0);
    rstn = 1'b1;
    tick(4);

    // Register readback after reset
    rd32("rb0_en", EXTSCH_ENABLE, d);   check("rb0_en", d, 32'd0);
    rd32("rb0_pend", EXTSCH_PENDING, d); check("rb0_pend", d, 32'd0);
    rd32("rb0_prio", EXTSCH_PRIO, d);   check("rb0_prio", d, 32'd0);
    rd32("rb0_thr", EXTSCH_THRESH, d);  check("rb0_thr", d, 32'd0);
    rd32("rb0_claim", EXTSCH_CLAIM, d); check("rb0_claim", d, 32'd0);

    cfg(8'hFF, 32'h0000_E4E4, 2'd1);
    rd32("rb1_en", EXTSCH_ENABLE, d);   check("rb1_en", d, 32'h0000_00FF);
    rd32("rb1_prio", EXTSCH_PRIO, d);   check("rb1_prio", d, 32'h0000_E4E4);
    rd32("rb1_thr", EXTSCH_THRESH, d);  check("rb1_thr", d, 32'h0000_0001);

    xfer(1'b1, EXTSCH_PENDING, BUS_ACC_4B, 32'hFF, d, rs, flt);
    check("pend_wr_fault", {31'd0, flt}, 32'd1);
    check("pend_wr_resp", {31'd0, rs}, 32'd0);
    xfer(1'b1, EXTSCH_ENABLE, BUS_ACC_2B, 32'h0, d, rs, flt);
    check("acc2b_fault", {31'd0, flt}, 32'd1);
    check("acc2b_resp", {31'd0, rs}, 32'd0);
    rd32("acc2b_noeffect", EXTSCH_ENABLE, d); check("acc2b_noeffect", d, 32'h0000_00FF);
    xfer(1'b0, 5'h02, BUS_ACC_4B, 32'h0, d, rs, flt);
    check("misalign_fault", {31'd0, flt}, 32'd1);
    xfer(1'b0, 5'h14, BUS_ACC_4B, 32'h0, d, rs, flt);
    check("unmapped_fault", {31'd0, flt}, 32'd1);
    xfer(1'b0, EXTSCH_PRIO, BUS_ACC_4B, 32'h0, d, rs, flt);
    check("legal_nofault", {31'd0, flt}, 32'd0);

    // Single source: edge to trigger takes three edges
    cfg(8'h01, 32'h0000_0003, 2'd0);
    raise(8'h01);
    tick(1); check("single_trig_early", {31'd0, trig}, 32'd0);
    tick(1); check("single_trig", {31'd0, trig}, 32'd1);
    claim_expect("single_claim", 1);
    check("single_trig_drop", {31'd0, trig}, 32'd0);
    rd32("single_pend", EXTSCH_PENDING, d); check("single_pend", d, 32'd0);
    wr32("single_done", EXTSCH_CLAIM, 32'd1);
    tick(2); check("single_idle_trig", {31'd0, trig}, 32'd0);
    claim_expect("single_idle_claim", 0);

    // Priority order with a tie between ids 3 and 6
    cfg(8'h26, 32'h0000_0C38, 2'd0);
    raise(8'h26);
    tick(2); check("prio_trig", {31'd0, trig}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      exp = (k == 0) ? 3 : (k == 1) ? 6 : 2;
      claim_expect("prio_claim", exp);
      wr32("prio_done", EXTSCH_CLAIM, 32'(exp));
      check("prio_trig_gap", {31'd0, trig}, 32'd0);
      tick(1); check("prio_trig_next", {31'd0, trig}, (k < 2) ? 32'd1 : 32'd0);
    end

    // Threshold masking
    cfg(8'h01, 32'h0000_0002, 2'd2);
    raise(8'h01);
    tick(3); check("thr_masked", {31'd0, trig}, 32'd0);
    m_thr = 2'd1;
    wr32("thr_lower", EXTSCH_THRESH, 32'd1);
    check("thr_trig_gap", {31'd0, trig}, 32'd0);
    tick(1); check("thr_trig", {31'd0, trig}, 32'd1);
    claim_expect("thr_claim", 1);

    // In service of id 1: re-pend, blocked claim, wrong completion
    raise(8'h01);
    tick(2);
    rd32("svc_pend", EXTSCH_PENDING, d); check("svc_pend", d, 32'h1);
    check("svc_trig_held", {31'd0, trig}, 32'd0);
    claim_expect("svc_claim_zero", 0);
    xfer(1'b1, EXTSCH_CLAIM, BUS_ACC_4B, 32'd2, d, rs, flt);
    check("svc_wrong_resp", {31'd0, rs}, 32'd1);
    check("svc_wrong_fault", {31'd0, flt}, 32'd0);
    tick(2); check("svc_wrong_trig", {31'd0, trig}, 32'd0);
    wr32("svc_done", EXTSCH_CLAIM, 32'd1);
    check("svc_done_gap", {31'd0, trig}, 32'd0);
    tick(1); check("svc_retrig", {31'd0, trig}, 32'd1);
    claim_expect("svc_reclaim", 1);
    wr32("svc_redone", EXTSCH_CLAIM, 32'd1);

    // Edge on the source being claimed in the same cycle: set wins
    raise(8'h01);
    tick(2); check("setwin_trig", {31'd0, trig}, 32'd1);
    src = 8'h01;
    @(negedge clk);
    src = 8'h00;
    claim_expect("setwin_claim", 1);
    m_pend[0] = 1'b1;
    rd32("setwin_pend", EXTSCH_PENDING, d); check("setwin_pend", d, {24'd0, m_pend});

    // Asynchronous reset in the middle of service
    rd32("arst_pre", EXTSCH_ENABLE, d); check("arst_pre", d, 32'h1);
    #1 rstn = 1'b0;
    #1;
    check("arst_trig", {31'd0, trig}, 32'd0);
    check("arst_resp", {31'd0, bus_if.resp}, 32'd0);
    check("arst_rdata", bus_if.rdata, 32'd0);
    tick(2);
    rstn = 1'b1;
    model_reset();
    tick(4);
    rd32("arst_pend", EXTSCH_PENDING, d); check("arst_pend", d, 32'd0);
    rd32("arst_en", EXTSCH_ENABLE, d);    check("arst_en", d, 32'd0);
    cfg(8'h01, 32'h0000_0003, 2'd0);
    tick(3); check("arst_noedge", {31'd0, trig}, 32'd0);
    raise(8'h01);
    tick(2); check("arst_edge_trig", {31'd0, trig}, 32'd1);
    claim_expect("arst_claim", 1);
    wr32("arst_done", EXTSCH_CLAIM, 32'd1);

    // Randomized configurations and edges against the model
    for (int it = 0; it < 40; it++) begin
      cfg(8'($urandom), 32'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 2)));
      raise(8'($urandom));
      tick(3);
      exp = m_best();
      check("rnd_trig", {31'd0, trig}, (exp != 0) ? 32'd1 : 32'd0);
      rd32("rnd_pend", EXTSCH_PENDING, d); check("rnd_pend", d, {24'd0, m_pend});
      n = 0;
      while (exp != 0 && n < 16) begin
        claim_expect("rnd_claim", exp);
        if ($urandom_range(0, 3) == 0) begin
          wr32("rnd_wrong", EXTSCH_CLAIM, 32'((exp % 8) + 1) + 32'd8);
          tick(1); check("rnd_wrong_trig", {31'd0, trig}, 32'd0);
        end
        wr32("rnd_done", EXTSCH_CLAIM, 32'(exp));
        check("rnd_gap", {31'd0, trig}, 32'd0);
        tick(1);
        exp = m_best();
        check("rnd_next_trig", {31'd0, trig}, (exp != 0) ? 32'd1 : 32'd0);
        n++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
